// File: rtl/clct_busy_keygen.sv
// clct_busy_keygen: slot-based busy windows around accepted best CLCT keys for the sorter busy inputs
module clct_busy_keygen #(
    parameter int MXHS    = 224,
    parameter int MXKEYBX = 8,
    parameter int NGRP    = 7,
    parameter int NSLOT   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               best_vld,
    input  logic               best_bsy,
    input  logic [MXKEYBX-1:0] best_key,
    input  logic [3:0]         spread,
    input  logic [3:0]         dead_time,
    output logic [MXHS-1:0]    busy_key,
    output logic [NGRP-1:0]    busy_grp,
    output logic [NSLOT-1:0]   slot_act,
    output logic [7:0]         ovf_cnt,
    output logic               key_err
);
    localparam int GW = MXHS / NGRP;
    localparam logic [MXKEYBX-1:0] KMAX = MXKEYBX'(MXHS - 1);

    logic [MXKEYBX-1:0] lo [NSLOT];
    logic [MXKEYBX-1:0] hi [NSLOT];
    logic [3:0]         cnt [NSLOT];
    logic [MXKEYBX-1:0] nlo [NSLOT];
    logic [MXKEYBX-1:0] nhi [NSLOT];
    logic [3:0]         ncnt [NSLOT];
    logic [NSLOT-1:0]   alloc;
    logic [MXHS-1:0]    nbusy;
    logic [NGRP-1:0]    ngrp;
    logic [MXKEYBX:0]   sum;
    logic [MXKEYBX-1:0] wlo, whi, sp;
    logic               key_ok, req, ld, found, drop;

    // window bounds, load request and lowest-free-slot allocation; a slot on its last clock counts as free
    always_comb begin
        sp     = MXKEYBX'(spread);
        sum    = {1'b0, best_key} + {1'b0, sp};
        wlo    = (best_key < sp) ? '0 : best_key - sp;
        whi    = (sum > {1'b0, KMAX}) ? KMAX : sum[MXKEYBX-1:0];
        key_ok = best_key < MXKEYBX'(MXHS);
        req    = best_vld & ~best_bsy;
        ld     = req & (dead_time != 4'd0) & key_ok;
        found  = 1'b0;
        alloc  = '0;
        for (int s = 0; s < NSLOT; s++) begin
            alloc[s] = ld & ~found & (cnt[s] <= 4'd1);
            found    = found | alloc[s];
            ncnt[s]  = alloc[s] ? dead_time : (cnt[s] != 4'd0) ? cnt[s] - 4'd1 : 4'd0;
            nlo[s]   = alloc[s] ? wlo : lo[s];
            nhi[s]   = alloc[s] ? whi : hi[s];
        end
        drop = ld & ~found;
    end

    // busy mask and group bits from the next-state slots so they line up with slot_act
    always_comb begin
        nbusy = '0;
        for (int k = 0; k < MXHS; k++)
            for (int s = 0; s < NSLOT; s++)
                nbusy[k] = nbusy[k] | ((ncnt[s] != 4'd0) && (nlo[s] <= MXKEYBX'(k)) && (MXKEYBX'(k) <= nhi[s]));
        for (int g = 0; g < NGRP; g++)
            ngrp[g] = |nbusy[g*GW +: GW];
    end

    // slot active flags follow the live counters
    always_comb begin
        for (int s = 0; s < NSLOT; s++)
            slot_act[s] = cnt[s] != 4'd0;
    end

    // slot state, registered outputs, saturating drop counter and bad-key pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < NSLOT; s++) begin
                lo[s]  <= '0;
                hi[s]  <= '0;
                cnt[s] <= '0;
            end
            busy_key <= '0;
            busy_grp <= '0;
            ovf_cnt  <= '0;
            key_err  <= 1'b0;
        end else begin
            for (int s = 0; s < NSLOT; s++) begin
                lo[s]  <= nlo[s];
                hi[s]  <= nhi[s];
                cnt[s] <= ncnt[s];
            end
            busy_key <= nbusy;
            busy_grp <= ngrp;
            ovf_cnt  <= (drop && ovf_cnt != 8'hff) ? ovf_cnt + 8'd1 : ovf_cnt;
            key_err  <= req & ~key_ok;
        end
    end
endmodule

// File: tb/tb_clct_busy_keygen.sv
// tb_clct_busy_keygen: directed stimulus against a time-based window model plus literal spot checks
module tb_clct_busy_keygen;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         best_vld = 1'b0, best_bsy = 1'b0;
    logic [7:0]   best_key = '0;
    logic [3:0]   spread = '0, dead_time = '0;
    logic [223:0] busy_key;
    logic [6:0]   busy_grp;
    logic [1:0]   slot_act;
    logic [7:0]   ovf_cnt;
    logic         key_err;

    int checks = 0, errors = 0;
    int cyc = 0;
    bit chk_en = 0;
    int m_end [2];
    int m_lo [2];
    int m_hi [2];
    int m_ovf = 0;
    bit m_kerr = 0;

    clct_busy_keygen dut (
        .clock(clock), .reset(reset), .best_vld(best_vld), .best_bsy(best_bsy),
        .best_key(best_key), .spread(spread), .dead_time(dead_time),
        .busy_key(busy_key), .busy_grp(busy_grp), .slot_act(slot_act),
        .ovf_cnt(ovf_cnt), .key_err(key_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [223:0] exp_busy();
        logic [223:0] b = '0;
        for (int s = 0; s < 2; s++)
            if (m_end[s] >= cyc)
                for (int k = m_lo[s]; k <= m_hi[s]; k++) b[k] = 1'b1;
        return b;
    endfunction

    function automatic logic [6:0] exp_grp(input logic [223:0] b);
        logic [6:0] g = '0;
        for (int i = 0; i < 224; i++) if (b[i]) g[i/32] = 1'b1;
        return g;
    endfunction

    // compare DUT against the model every cycle once reset has been applied
    always @(negedge clock) begin
        if (chk_en) begin
            logic [223:0] eb;
            logic [1:0] ea;
            eb = exp_busy();
            for (int s = 0; s < 2; s++) ea[s] = m_end[s] >= cyc;
            chk("busy_key", busy_key, eb);
            chk("busy_grp", busy_grp, exp_grp(eb));
            chk("slot_act", slot_act, ea);
            chk("ovf_cnt", ovf_cnt, m_ovf);
            chk("key_err", key_err, m_kerr);
        end
    end

    // one clock: drive inputs, advance the model at the edge, return at the following falling edge
    task automatic step(input bit v, input bit b, input int key, input int sp, input int dt, input bit r);
        int fs;
        best_vld = v; best_bsy = b; best_key = key[7:0]; spread = sp[3:0]; dead_time = dt[3:0]; reset = r;
        @(posedge clock);
        if (r) begin
            m_end[0] = -1; m_end[1] = -1; m_ovf = 0; m_kerr = 0;
        end else begin
            m_kerr = v && !b && key >= 224;
            if (v && !b && dt != 0 && key < 224) begin
                fs = -1;
                for (int s = 1; s >= 0; s--) if (m_end[s] <= cyc) fs = s;
                if (fs >= 0) begin
                    m_lo[fs] = (key - sp < 0) ? 0 : key - sp;
                    m_hi[fs] = (key + sp > 223) ? 223 : key + sp;
                    m_end[fs] = cyc + dt;
                end else if (m_ovf < 255) m_ovf++;
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_end[0] = -1; m_end[1] = -1; m_lo = '{0, 0}; m_hi = '{0, 0};
        @(negedge clock);
        step(0, 0, 0, 0, 0, 1);
        chk_en = 1;
        step(0, 0, 0, 0, 0, 1);
        chk("rst busy_key", busy_key, 0);
        chk("rst slot_act", slot_act, 0);
        chk("rst ovf_cnt", ovf_cnt, 0);

        step(1, 0, 100, 3, 4, 0);
        chk("t1 window", busy_key[104:96], 9'h0fe);
        chk("t1 grp", busy_grp, 7'b0001000);
        idle(3);
        chk("t1 last clk", slot_act, 2'b01);
        idle(1);
        chk("t1 expired", busy_grp, 7'b0);

        step(1, 0, 1, 5, 3, 0);
        chk("t2 low edge", busy_key[7:0], 8'h7f);
        idle(3);
        step(1, 0, 223, 5, 3, 0);
        chk("t2 high edge", busy_key[223:216], 8'hfc);
        chk("t2 no wrap", busy_key[7:0], 8'h00);
        idle(3);

        step(1, 0, 50, 0, 2, 0);
        step(1, 0, 60, 0, 8, 0);
        step(1, 0, 70, 1, 3, 0);
        chk("t4 reuse", busy_key[71:69], 3'b111);
        chk("t4 old gone", busy_key[50], 1'b0);
        chk("t4 slot1", busy_key[60], 1'b1);
        chk("t4 no ovf", ovf_cnt, 0);
        idle(10);

        step(1, 0, 40, 0, 8, 0);
        step(1, 0, 150, 0, 8, 0);
        step(1, 0, 10, 0, 8, 0);
        chk("t3 ovf1", ovf_cnt, 1);
        chk("t3 grp", busy_grp, 7'b0010010);
        for (int i = 0; i < 320; i++) step(1, 0, 10, 1, 15, 0);
        chk("t3 ovf sat", ovf_cnt, 255);
        idle(16);

        step(1, 1, 80, 2, 4, 0);
        chk("t5 bsy", slot_act, 2'b00);
        step(1, 0, 80, 2, 0, 0);
        chk("t5 dead0", slot_act, 2'b00);
        step(1, 0, 230, 2, 4, 0);
        chk("t5 key_err", key_err, 1'b1);
        chk("t5 no load", slot_act, 2'b00);
        idle(1);
        chk("t5 pulse end", key_err, 1'b0);

        step(1, 0, 100, 2, 8, 0);
        chk("t6 pre", slot_act, 2'b01);
        step(1, 0, 30, 2, 8, 1);
        chk("t6 busy_key", busy_key, 0);
        chk("t6 slot_act", slot_act, 0);
        chk("t6 ovf", ovf_cnt, 0);
        idle(2);
        chk("t6 stays clear", busy_grp, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
